// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phy_pkg
// Purpose  : Shared PHY constants and receive-FSM state encoding, used by both
//            the transmitter and the receive alignment path.
// Revision : 1.0 - initial release
// ============================================================================
package phy_pkg;

    // Idle / alignment symbol
    localparam logic [7:0] COMMA = 8'hBC;

    // Parallel word width shared with the transmitter
    localparam int WORD_W = 32;

    // Width of the byte-lane index inside a word (4 lanes)
    localparam int BYTE_IDX_W = 2;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/phy_comma_detect.sv
`default_nettype none
// ============================================================================
// Module   : phy_comma_detect
// Purpose  : 8-bit serial shift register; presents the byte ending on the
//            current bit and flags when it equals the comma symbol.
// Revision : 1.0 - initial release
// ============================================================================
module phy_comma_detect #(
    parameter logic [7:0] COMMA = phy_pkg::COMMA
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] cand,
    output logic       is_comma
);

    logic [7:0] r_sr;

    // Shift in one bit per cycle, MSB first
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_sr <= 8'd0;
        end else begin
            r_sr <= {r_sr[6:0], data_in};
        end
    end

    // The candidate includes the bit being sampled this edge
    always_comb begin
        cand     = {r_sr[6:0], data_in};
        is_comma = (cand == COMMA);
    end

endmodule
`default_nettype wire

// File: rtl/phy_rx_serial_align.sv
`default_nettype none
// ============================================================================
// Module   : phy_rx_serial_align
// Purpose  : Serial-to-parallel receive stage. Finds byte alignment on a run
//            of consecutive commas, then reassembles 32-bit words.
// Revision : 1.0 - initial release
// ============================================================================
module phy_rx_serial_align #(
    parameter logic [7:0] COMMA   = phy_pkg::COMMA,
    parameter int         N_COMMA = 4,
    parameter int         WORD_W  = phy_pkg::WORD_W
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              active
);

    import phy_pkg::*;

    // bc_cnt value at which the next aligned comma completes the lock run
    localparam logic [3:0] c_BC_LAST     = 4'(N_COMMA - 1);
    // valid_out spans one full word period (32 edges) after a word lands
    localparam logic [4:0] c_HOLD_RELOAD = 5'd31;

    logic [7:0]            w_cand;
    logic                  w_is_comma;
    logic                  w_byte_done;
    logic                  w_word_done;

    rx_state_t             r_state,     w_state;
    logic [2:0]            r_bit_cnt,   w_bit_cnt;
    logic [3:0]            r_bc_cnt,    w_bc_cnt;
    logic [BYTE_IDX_W-1:0] r_byte_idx,  w_byte_idx;
    logic [4:0]            r_hold_cnt,  w_hold_cnt;
    logic [WORD_W-9:0]     r_word,      w_word;
    logic [WORD_W-1:0]     r_data_out,  w_data_out;
    logic                  r_valid_out, w_valid_out;
    logic                  r_active,    w_active;

    phy_comma_detect #(
        .COMMA    (COMMA)
    ) u_comma_detect (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .cand     (w_cand),
        .is_comma (w_is_comma)
    );

    assign w_byte_done = (r_bit_cnt == 3'd7);

    // Next-state: alignment FSM, byte assembly and valid hold timer
    always_comb begin
        w_state     = r_state;
        w_bit_cnt   = r_bit_cnt + 3'd1;
        w_bc_cnt    = r_bc_cnt;
        w_byte_idx  = r_byte_idx;
        w_word      = r_word;
        w_data_out  = r_data_out;
        w_word_done = 1'b0;

        case (r_state)
            SEARCH: begin
                // Any bit offset may hold the comma; the next byte
                // boundary follows 8 edges after this one.
                if (w_is_comma) begin
                    w_bit_cnt = 3'd0;
                    w_bc_cnt  = 4'd1;
                    w_state   = LOCKING;
                end
            end
            LOCKING: begin
                if (w_byte_done) begin
                    if (w_is_comma) begin
                        w_bc_cnt = r_bc_cnt + 4'd1;
                        if (r_bc_cnt == c_BC_LAST) begin
                            w_state    = ACTIVE;
                            w_byte_idx = '0;
                        end
                    end else begin
                        w_bc_cnt = 4'd0;
                        w_state  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (w_byte_done) begin
                    case (r_byte_idx)
                        2'd0: begin
                            // A leading comma is idle fill, not data
                            if (!w_is_comma) begin
                                w_word[23:16] = w_cand;
                                w_byte_idx    = 2'd1;
                            end
                        end
                        2'd1: begin
                            w_word[15:8] = w_cand;
                            w_byte_idx   = 2'd2;
                        end
                        2'd2: begin
                            w_word[7:0] = w_cand;
                            w_byte_idx  = 2'd3;
                        end
                        default: begin
                            w_data_out  = {r_word, w_cand};
                            w_word_done = 1'b1;
                            w_byte_idx  = 2'd0;
                        end
                    endcase
                end
            end
            default: begin
                w_state = SEARCH;
            end
        endcase

        // The counter reaches zero on the 31st edge after a word, so
        // valid_out drops on the 32nd edge unless another word lands there.
        w_valid_out = r_valid_out;
        w_hold_cnt  = r_hold_cnt;
        if (w_word_done) begin
            w_valid_out = 1'b1;
            w_hold_cnt  = c_HOLD_RELOAD;
        end else if (r_hold_cnt != 5'd0) begin
            w_hold_cnt = r_hold_cnt - 5'd1;
        end else begin
            w_valid_out = 1'b0;
        end

        w_active = (w_state == ACTIVE);
    end

    // State and datapath registers
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state     <= SEARCH;
            r_bit_cnt   <= 3'd0;
            r_bc_cnt    <= 4'd0;
            r_byte_idx  <= '0;
            r_hold_cnt  <= 5'd0;
            r_word      <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_bit_cnt   <= w_bit_cnt;
            r_bc_cnt    <= w_bc_cnt;
            r_byte_idx  <= w_byte_idx;
            r_hold_cnt  <= w_hold_cnt;
            r_word      <= w_word;
            r_data_out  <= w_data_out;
            r_valid_out <= w_valid_out;
            r_active    <= w_active;
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign active    = r_active;

endmodule
`default_nettype wire

// File: tb/tb_phy_rx_serial_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_rx_serial_align
// Purpose  : Directed bench for the serial receive alignment stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phy_rx_serial_align;

    logic        clk_32f;
    logic        reset;
    logic        data_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        active;

    int total;
    int bad;
    int vseen;
    int vlow;

    phy_rx_serial_align #(
        .COMMA     (8'hBC),
        .N_COMMA   (4),
        .WORD_W    (32)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bit per edge; outputs sampled 1 time unit after the edge
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        if (valid_out) vseen++;
        else           vlow++;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        data_in = 1'b0;
        @(posedge clk_32f);
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        vseen   = 0;
        vlow    = 0;
        reset   = 1'b0;
        data_in = 1'b0;

        // ---- Aligned lock ----
        do_reset();
        chk("rst_data",   data_out,  32'h0);
        chk("rst_valid",  {31'd0, valid_out}, 32'd0);
        chk("rst_active", {31'd0, active},    32'd0);
        vseen = 0;
        send_bits(32'h00BCBCBC, 24);
        send_bits(32'h0000005E, 7);
        chk("t1_active_pre", {31'd0, active}, 32'd0);
        send_bit(1'b0);
        chk("t1_active_rise", {31'd0, active}, 32'd1);
        send_bits(32'h12345678, 32);
        chk("t1_data",  data_out, 32'h12345678);
        chk("t1_valid", {31'd0, valid_out}, 32'd1);
        chk("t1_vcount_pre", vseen, 1);
        vseen = 0;
        send_bits(32'hBCBCBCBC, 32);
        chk("t1_hold_len",  vseen, 31);
        chk("t1_valid_end", {31'd0, valid_out}, 32'd0);
        chk("t1_data_held", data_out, 32'h12345678);

        // ---- Back-to-back words and idle gap (still locked) ----
        send_bits(32'hDDDDDDDD, 32);
        chk("t4_data0",  data_out, 32'hDDDDDDDD);
        chk("t4_valid0", {31'd0, valid_out}, 32'd1);
        vlow = 0;
        send_bits(32'hCCCCCCCC, 32);
        chk("t4_b2b_low", vlow, 0);
        chk("t4_data1",   data_out, 32'hCCCCCCCC);
        vlow = 0;
        send_bits(32'h0000BCBC, 16);
        send_bits(32'h00BCBCBC, 32);
        chk("t4_gap_low", vlow, 16);
        chk("t4_data2",   data_out, 32'h00BCBCBC);
        chk("t4_valid2",  {31'd0, valid_out}, 32'd1);

        // ---- Misaligned start ----
        do_reset();
        vseen = 0;
        send_bits(32'h5, 3);
        send_bits(32'hBCBCBCBC, 32);
        chk("t2_active", {31'd0, active}, 32'd1);
        send_bits(32'hFFFFFFFF, 32);
        chk("t2_data",   data_out, 32'hFFFFFFFF);
        chk("t2_valid",  {31'd0, valid_out}, 32'd1);
        chk("t2_no_spurious", vseen, 1);

        // ---- Broken comma run ----
        do_reset();
        send_bits(32'hBCBC, 16);
        chk("t3_active_2c", {31'd0, active}, 32'd0);
        send_bits(32'h55, 8);
        chk("t3_active_55", {31'd0, active}, 32'd0);
        send_bits(32'hBCBCBC, 24);
        chk("t3_active_3c", {31'd0, active}, 32'd0);
        send_bits(32'hBC, 8);
        chk("t3_active_4c", {31'd0, active}, 32'd1);
        send_bits(32'hEEEEEEEE, 32);
        chk("t3_data",  data_out, 32'hEEEEEEEE);
        chk("t3_valid", {31'd0, valid_out}, 32'd1);

        // ---- Reset mid-word ----
        send_bits(32'hAAAA, 16);
        reset = 1'b1;
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        chk("t5_rst_data",   data_out, 32'h0);
        chk("t5_rst_valid",  {31'd0, valid_out}, 32'd0);
        chk("t5_rst_active", {31'd0, active},    32'd0);
        vseen = 0;
        send_bits(32'hBCBCBC, 24);
        send_bits(32'hAAAAAAAA, 32);
        chk("t5_3c_active", {31'd0, active}, 32'd0);
        chk("t5_no_pulse",  vseen, 0);
        chk("t5_data_zero", data_out, 32'h0);
        send_bits(32'hBCBCBCBC, 32);
        chk("t5_relock", {31'd0, active}, 32'd1);
        send_bits(32'hAAAAAAAA, 32);
        chk("t5_data",  data_out, 32'hAAAAAAAA);
        chk("t5_valid", {31'd0, valid_out}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
